fill_rect: RTL and testbench

//   Parametrised successor to the lab fillscreen engine: fills an arbitrary clipped rectangle of the
//   VGA framebuffer, one pixel per accepted cycle, with a selectable colour pattern. Sits between the
//   lab top-level control FSM and the vga_adapter plot port; adds vga_ready backpressure and a busy flag.

---
 rtl/fill_rect_if.sv | 32 +++
 rtl/fill_rect.sv | 168 ++++++++++++++++
 tb/tb_fill_rect.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fill_rect_if.sv
// Request/pixel bus between the control FSM, the rectangle fill engine and the VGA plot port.
// The engine connects through the slave modport; the controller/sink side uses master.
interface fill_rect_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      x0;
    logic [X_W-1:0]      x1;
    logic [Y_W-1:0]      y0;
    logic [Y_W-1:0]      y1;
    logic [COLOUR_W-1:0] colour;
    logic [1:0]          mode;
    logic                vga_ready;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport slave (
        input  start, x0, x1, y0, y1, colour, mode, vga_ready,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport master (
        output start, x0, x1, y0, y1, colour, mode, vga_ready,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/fill_rect.sv
// Fills a clipped framebuffer rectangle column-major, one pixel per accepted cycle, with a
// selectable colour pattern; all outputs are registered and vga_ready applies backpressure.
module fill_rect #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    fill_rect_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    state_t              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [X_W-1:0]      xe_q, xe_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [Y_W-1:0]      ye_q, ye_d;
    logic [COLOUR_W-1:0] c_q, c_d;
    logic [1:0]          mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                plot_q, plot_d;

    logic [X_W-1:0]      xe_s;
    logic [Y_W-1:0]      ye_s;
    logic                empty_s;

    // Pattern colour at (px,py); the truncating casts give the mod 2**COLOUR_W stripes.
    function automatic logic [COLOUR_W-1:0] pix_colour(
        input logic [X_W-1:0]      px,
        input logic [Y_W-1:0]      py,
        input logic [COLOUR_W-1:0] c,
        input logic [1:0]          m
    );
        logic [COLOUR_W-1:0] r;
        r = c;
        case (m)
            2'd0:    r = c;
            2'd1:    r = COLOUR_W'(px);
            2'd2:    r = COLOUR_W'(py);
            2'd3:    r = (px[0] ^ py[0]) ? ~c : c;
            default: r = c;
        endcase
        return r;
    endfunction

    // Clip the requested bounds to the screen and detect an empty rectangle.
    always_comb begin
        xe_s    = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
        ye_s    = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;
        empty_s = (bus.x0 > xe_s) || (bus.y0 > ye_s);
    end

    // Next-state, scan advance and registered-output values.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        xe_d     = xe_q;
        y0_d     = y0_q;
        ye_d     = ye_q;
        c_d      = c_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (empty_s) begin
                        state_d = DONE;
                    end else begin
                        state_d  = DRAW;
                        xe_d     = xe_s;
                        y0_d     = bus.y0;
                        ye_d     = ye_s;
                        c_d      = bus.colour;
                        mode_d   = bus.mode;
                        x_d      = bus.x0;
                        y_d      = bus.y0;
                        colour_d = pix_colour(bus.x0, bus.y0, bus.colour, bus.mode);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRAW: begin
                if (bus.vga_ready) begin
                    if (y_q == ye_q) begin
                        if (x_q == xe_q) begin
                            state_d = DONE;
                        end else begin
                            x_d      = x_q + X_W'(1'b1);
                            y_d      = y0_q;
                            colour_d = pix_colour(x_q + X_W'(1'b1), y0_q, c_q, mode_q);
                        end
                    end else begin
                        y_d      = y_q + Y_W'(1'b1);
                        colour_d = pix_colour(x_q, y_q + Y_W'(1'b1), c_q, mode_q);
                    end
                end else begin
                    state_d = DRAW;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == DRAW);
        plot_d = (state_d == DRAW);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset overrides any in-flight fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            xe_q     <= '0;
            y0_q     <= '0;
            ye_q     <= '0;
            c_q      <= '0;
            mode_q   <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            xe_q     <= xe_d;
            y0_q     <= y0_d;
            ye_q     <= ye_d;
            c_q      <= c_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = x_q;
    assign bus.vga_y      = y_q;
    assign bus.vga_colour = colour_q;
endmodule

// File: tb/tb_fill_rect.sv
// Randomised bench for fill_rect: a queue of expected pixels built from the rectangle rules is
// compared against every transferred pixel, plus latency, backpressure, clip and reset cases.
module tb_fill_rect;
    logic clk = 1'b0;
    logic rst;
    int   err_cnt   = 0;
    int   check_cnt = 0;

    always #5 clk = ~clk;

    fill_rect_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

    fill_rect #(
        .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7), .COLOUR_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_colour(input int x, input int y, input int c, input int m);
        case (m)
            0:       return 3'(c);
            1:       return 3'(x % 8);
            2:       return 3'(y % 8);
            default: return ((x + y) % 2 == 0) ? 3'(c) : 3'(7 - c);
        endcase
    endfunction

    // rmode: 0 ready high, 1 pattern 1,0,0 repeating, 2 random. abort_at>0 resets on that pixel.
    task automatic fill(input int ax0, input int ax1, input int ay0, input int ay1,
                        input int ac, input int am, input int rmode, input int abort_at);
        int          xe, ye, n, cyc, got, limit, ph;
        logic [17:0] exp_q[$];
        logic [17:0] cur, prev;
        logic        prev_stall, rdy;
        xe = (ax1 > 159) ? 159 : ax1;
        ye = (ay1 > 119) ? 119 : ay1;
        for (int x = ax0; x <= xe; x++)
            for (int y = ay0; y <= ye; y++)
                exp_q.push_back({8'(x), 7'(y), ref_colour(x, y, ac, am)});
        n     = exp_q.size();
        limit = 4 * n + 20;
        @(negedge clk);
        bus.x0 = 8'(ax0); bus.x1 = 8'(ax1);
        bus.y0 = 7'(ay0); bus.y1 = 7'(ay1);
        bus.colour = 3'(ac); bus.mode = 2'(am);
        bus.vga_ready = 1'b1;
        bus.start = 1'b1;
        cyc = 0; got = 0; ph = 0; prev_stall = 1'b0; prev = 18'd0;
        while (1'b1) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.done) break;
            if (cyc > limit) begin
                check_val("timeout", 32'(cyc), 32'(limit));
                break;
            end
            cur = {bus.vga_x, bus.vga_y, bus.vga_colour};
            check_val("busy_plot", {30'd0, bus.busy, bus.vga_plot}, 32'd3);
            if (prev_stall) check_val("hold", 32'(cur), 32'(prev));
            bus.x0 = 8'($urandom); bus.x1 = 8'($urandom);
            bus.y0 = 7'($urandom); bus.y1 = 7'($urandom);
            bus.colour = 3'($urandom); bus.mode = 2'($urandom);
            if (rmode == 0)      rdy = 1'b1;
            else if (rmode == 1) rdy = (ph % 3 == 0);
            else                 rdy = 1'($urandom_range(0, 1));
            ph++;
            bus.vga_ready = rdy;
            if (abort_at > 0 && got == abort_at - 1) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_val("rst_out", {14'd0, bus.busy, bus.done, bus.vga_plot,
                                      bus.vga_x, bus.vga_y, bus.vga_colour}, 32'd0);
                rst = 1'b0;
                bus.start = 1'b0;
                return;
            end
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_pix", 32'(cur), 32'h3ffff);
                end else begin
                    check_val("pix", 32'(cur), 32'(exp_q.pop_front()));
                    got++;
                end
            end
            prev = cur;
            prev_stall = !rdy;
        end
        check_val("done", {31'd0, bus.done}, 32'd1);
        check_val("plot_off", {31'd0, bus.vga_plot}, 32'd0);
        check_val("count", 32'(got), 32'(n));
        if (rmode == 0) check_val("latency", 32'(cyc), 32'(n + 1));
        @(posedge clk);
        @(negedge clk);
        check_val("done_held", {31'd0, bus.done}, 32'd1);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("done_drop", {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        int rx0, rx1, ry0, ry1;
        rst = 1'b1;
        bus.start = 1'b0; bus.x0 = 8'd0; bus.x1 = 8'd0; bus.y0 = 7'd0; bus.y1 = 7'd0;
        bus.colour = 3'd0; bus.mode = 2'd0; bus.vga_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset", {14'd0, bus.busy, bus.done, bus.vga_plot,
                            bus.vga_x, bus.vga_y, bus.vga_colour}, 32'd0);
        rst = 1'b0;

        fill(0, 159, 0, 119, 0, 1, 0, 0);
        fill(10, 12, 5, 6, 5, 0, 0, 0);
        fill(0, 1, 0, 1, 2, 0, 1, 0);
        fill(155, 200, 116, 127, 6, 2, 0, 0);
        fill(7, 3, 0, 5, 1, 0, 0, 0);
        fill(170, 180, 0, 5, 1, 0, 0, 0);
        fill(0, 159, 0, 119, 4, 0, 0, 50);
        fill(0, 1, 0, 1, 4, 0, 0, 0);
        fill(0, 1, 0, 1, 3, 3, 0, 0);

        for (int i = 0; i < 25; i++) begin
            rx0 = $urandom_range(0, 165);
            rx1 = rx0 + $urandom_range(0, 5) - 1;
            if (rx1 < 0) rx1 = 0;
            if (rx1 > 255) rx1 = 255;
            ry0 = $urandom_range(0, 122);
            ry1 = ry0 + $urandom_range(0, 5) - 1;
            if (ry1 < 0) ry1 = 0;
            if (ry1 > 127) ry1 = 127;
            fill(rx0, rx1, ry0, ry1, $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 2), 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end
endmodule
